// File: rtl/moving_avg_param.sv
// rtl/moving_avg_param.sv - parameterised moving average with sequential restoring divider
//
// Purpose:
//   Keeps a running sum over the last W accepted samples (W = clamped mask)
//   and divides it by the number of samples in the window using a one-bit-per-clock
//   restoring divider. One result is produced per accepted sample.
//
// Ports:
//   clk       in   1              rising-edge clock
//   nRST      in   1              asynchronous active-low reset
//   e_in      in   1              sample valid strobe
//   data_in   in   DATA_W         unsigned sample
//   mask      in   DEPTH_LOG2+1   requested window length (0 -> 1, clamped to 2^DEPTH_LOG2)
//   clr       in   1              synchronous flush (sum, fill, ovr, aborts division)
//   data_out  out  DATA_W         registered average, holds between results
//   e_out     out  1              one-cycle result valid pulse
//   busy      out  1              division in progress
//   ovr       out  1              sticky: a sample arrived while busy and was dropped

module moving_avg_param #(
  parameter int DATA_W     = 10,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  nRST,
  input  logic                  e_in,
  input  logic [DATA_W-1:0]     data_in,
  input  logic [DEPTH_LOG2:0]   mask,
  input  logic                  clr,
  output logic [DATA_W-1:0]     data_out,
  output logic                  e_out,
  output logic                  busy,
  output logic                  ovr
);

  localparam int SUM_W = DATA_W + DEPTH_LOG2;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int RW    = DEPTH_LOG2 + 1;      // window / fill / divisor / remainder width
  localparam int CNT_W = $clog2(SUM_W);
  localparam logic [RW-1:0]    WMAX = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SUM_W - 1);

  typedef enum logic {IDLE, DIV} state_t;

  state_t                  state_q, state_d;
  logic [SUM_W-1:0]        sum_q,   sum_d;
  logic [RW-1:0]           fill_q,  fill_d;
  logic [DEPTH_LOG2-1:0]   wp_q,    wp_d;
  logic [RW-1:0]           wlat_q,  wlat_d;
  logic [SUM_W-1:0]        quo_q,   quo_d;
  logic [RW-1:0]           rem_q,   rem_d;
  logic [RW-1:0]           dvs_q,   dvs_d;
  logic [CNT_W-1:0]        cnt_q,   cnt_d;
  logic [DATA_W-1:0]       dout_q,  dout_d;
  logic                    eout_q,  eout_d;
  logic                    ovr_q,   ovr_d;

  // Sample ring buffer; never reset because fill gating keeps unwritten
  // entries from ever being subtracted.
  logic [DATA_W-1:0]       smp_mem [DEPTH];
  logic                    mem_we;

  logic [RW-1:0]           w_eff;
  logic [DEPTH_LOG2-1:0]   rd_idx;
  logic [SUM_W-1:0]        data_ext, old_ext;
  logic                    win_chg;
  logic [SUM_W-1:0]        base_sum, sum_new;
  logic [RW-1:0]           base_fill, fill_new;

  logic [RW:0]             shifted;
  logic                    ge;
  logic [RW-1:0]           rem_step;
  logic [SUM_W-1:0]        quo_step;

  // Effective window length.
  always_comb begin
    w_eff = mask;
    if (mask == '0) begin
      w_eff = RW'(1);
    end else if (mask > WMAX) begin
      w_eff = WMAX;
    end
  end

  // Oldest sample in a full window. For W = 2^DEPTH_LOG2 the low bits of W are
  // zero, so this is the entry about to be overwritten, which is the intent.
  assign rd_idx   = wp_q - w_eff[DEPTH_LOG2-1:0];
  assign data_ext = {{DEPTH_LOG2{1'b0}}, data_in};
  assign old_ext  = {{DEPTH_LOG2{1'b0}}, smp_mem[rd_idx]};

  // Accumulator update for a candidate acceptance. Subtracting the outgoing
  // sample before adding the new one keeps the intermediate inside SUM_W bits.
  always_comb begin
    win_chg   = (w_eff != wlat_q);
    base_sum  = win_chg ? '0 : sum_q;
    base_fill = win_chg ? '0 : fill_q;
    if (base_fill < w_eff) begin
      sum_new  = base_sum + data_ext;
      fill_new = base_fill + RW'(1);
    end else begin
      sum_new  = base_sum - old_ext + data_ext;
      fill_new = base_fill;
    end
  end

  // One restoring-division step: quo_q shifts the dividend out of its MSB
  // while quotient bits shift in at the LSB.
  always_comb begin
    shifted  = {rem_q, quo_q[SUM_W-1]};
    ge       = (shifted >= {1'b0, dvs_q});
    rem_step = ge ? RW'(shifted - {1'b0, dvs_q}) : shifted[RW-1:0];
    quo_step = {quo_q[SUM_W-2:0], ge};
  end

  assign mem_we = e_in && !clr && (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    fill_d  = fill_q;
    wp_d    = wp_q;
    wlat_d  = wlat_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    eout_d  = 1'b0;
    ovr_d   = ovr_q;

    if (clr) begin
      // Flush wins over everything, including a coincident sample.
      sum_d   = '0;
      fill_d  = '0;
      ovr_d   = 1'b0;
      cnt_d   = '0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (e_in) begin
            wlat_d  = w_eff;
            sum_d   = sum_new;
            fill_d  = fill_new;
            wp_d    = wp_q + DEPTH_LOG2'(1);
            quo_d   = sum_new;
            rem_d   = '0;
            dvs_d   = fill_new;
            cnt_d   = '0;
            state_d = DIV;
          end
        end
        DIV: begin
          if (e_in) begin
            ovr_d = 1'b1;
          end
          quo_d = quo_step;
          rem_d = rem_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            // Average never exceeds 2^DATA_W-1, so the low bits are exact.
            dout_d  = quo_step[DATA_W-1:0];
            eout_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      sum_q   <= '0;
      fill_q  <= '0;
      wp_q    <= '0;
      wlat_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      eout_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      fill_q  <= fill_d;
      wp_q    <= wp_d;
      wlat_q  <= wlat_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      eout_q  <= eout_d;
      ovr_q   <= ovr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      smp_mem[wp_q] <= data_in;
    end
  end

  assign data_out = dout_q;
  assign e_out    = eout_q;
  assign busy     = (state_q == DIV);
  assign ovr      = ovr_q;

endmodule

// File: tb/tb_moving_avg_param.sv
// tb/tb_moving_avg_param.sv - self-checking bench for moving_avg_param

module tb_moving_avg_param;

  logic        clk = 1'b0;
  logic        nRST;
  logic        e_in;
  logic [9:0]  data_in;
  logic [8:0]  mask;
  logic        clr;
  logic [9:0]  data_out;
  logic        e_out;
  logic        busy;
  logic        ovr;

  moving_avg_param #(.DATA_W(10), .DEPTH_LOG2(8)) dut (
    .clk      (clk),
    .nRST     (nRST),
    .e_in     (e_in),
    .data_in  (data_in),
    .mask     (mask),
    .clr      (clr),
    .data_out (data_out),
    .e_out    (e_out),
    .busy     (busy),
    .ovr      (ovr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the window as a queue of sample values.
  int win_q[$];
  int lat_w = 0;

  typedef struct {
    int mask;
    int data;
    int exp;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int eff_w(input int m);
    if (m == 0) return 1;
    if (m > 256) return 256;
    return m;
  endfunction

  function automatic int model_accept(input int d, input int m);
    int w;
    int s;
    w = eff_w(m);
    if (w != lat_w) win_q.delete();
    lat_w = w;
    win_q.push_back(d);
    while (win_q.size() > w) void'(win_q.pop_front());
    s = 0;
    foreach (win_q[i]) s += win_q[i];
    return s / win_q.size();
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) check("wait_idle_timeout", busy, 0);
  endtask

  // Accept one sample, then require a single e_out pulse exactly 18 cycles later
  // carrying the model's average.
  task automatic do_sample(input int d, input int m, input string tag, output int got);
    int exp;
    int cyc;
    wait_idle();
    @(negedge clk);
    data_in = d[9:0];
    mask    = m[8:0];
    e_in    = 1'b1;
    @(posedge clk); #1;
    e_in = 1'b0;
    exp  = model_accept(d, m);
    check({tag, "_busy_after_accept"}, busy, 1);
    cyc = 0;
    while (!e_out && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_latency"}, cyc, 18);
    check({tag, "_value"}, data_out, exp);
    check({tag, "_busy_at_result"}, busy, 0);
    got = int'(data_out);
    @(posedge clk); #1;
    check({tag, "_single_pulse"}, e_out, 0);
  endtask

  task automatic no_pulse_for(input int ncyc, input string tag);
    int pulses;
    pulses = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      if (e_out) pulses++;
    end
    check({tag, "_no_e_out"}, pulses, 0);
  endtask

  initial begin
    int got;
    int exp;
    int dprev;
    int m;
    int cyc;

    vecs[0]  = '{4, 10, 10};
    vecs[1]  = '{4, 20, 15};
    vecs[2]  = '{4, 30, 20};
    vecs[3]  = '{4, 40, 25};
    vecs[4]  = '{4, 50, 35};
    vecs[5]  = '{3, 1, 1};
    vecs[6]  = '{3, 2, 1};
    vecs[7]  = '{4, 8, 8};
    vecs[8]  = '{4, 8, 8};
    vecs[9]  = '{4, 8, 8};
    vecs[10] = '{4, 8, 8};
    vecs[11] = '{2, 100, 100};
    vecs[12] = '{2, 50, 75};
    vecs[13] = '{0, 7, 7};
    vecs[14] = '{0, 9, 9};

    nRST = 1'b0; e_in = 1'b0; data_in = '0; mask = '0; clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data_out", data_out, 0);
    check("reset_e_out", e_out, 0);
    check("reset_busy", busy, 0);
    check("reset_ovr", ovr, 0);
    @(negedge clk);
    nRST = 1'b1;

    for (int i = 0; i < 15; i++) begin
      do_sample(vecs[i].data, vecs[i].mask, $sformatf("vec%0d", i), got);
      check($sformatf("vec%0d_table", i), got, vecs[i].exp);
    end

    // Full-scale window with pointer rollover; mask 300 clamps to the same W.
    for (int i = 0; i < 300; i++) begin
      do_sample(1023, (i < 150) ? 256 : 300, $sformatf("full%0d", i), got);
      if (got != 1023) check($sformatf("full%0d_const", i), got, 1023);
    end

    // Dropped sample while busy.
    wait_idle();
    @(negedge clk);
    data_in = 10'd200; mask = 9'd4; e_in = 1'b1;
    @(posedge clk); #1;
    e_in = 1'b0;
    exp = model_accept(200, 4);
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk);
    data_in = 10'd999 & 10'h3ff; e_in = 1'b1;
    @(posedge clk); #1;
    e_in = 1'b0;
    check("drop_ovr_set", ovr, 1);
    check("drop_still_busy", busy, 1);
    cyc = 0;
    while (!e_out && cyc < 40) begin @(posedge clk); #1; cyc++; end
    check("drop_result_latency", cyc, 13);
    check("drop_result_value", data_out, exp);
    do_sample(300, 4, "after_drop", got);
    check("after_drop_ovr_sticky", ovr, 1);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("clr_ovr", ovr, 0);
    win_q.delete();

    // Reset in the middle of a division.
    do_sample(60, 4, "pre_rst", got);
    @(negedge clk);
    data_in = 10'd500; e_in = 1'b1;
    @(posedge clk); #1;
    e_in = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    nRST = 1'b0;
    #1;
    check("rst_mid_data_out", data_out, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_e_out", e_out, 0);
    check("rst_mid_ovr", ovr, 0);
    win_q.delete();
    lat_w = 0;
    @(negedge clk);
    nRST = 1'b1;
    no_pulse_for(25, "rst_mid");
    do_sample(77, 4, "first_after_rst", got);
    do_sample(33, 4, "second_after_rst", got);

    // clr in the middle of a division.
    dprev = int'(data_out);
    @(negedge clk);
    data_in = 10'd900; mask = 9'd4; e_in = 1'b1;
    @(posedge clk); #1;
    e_in = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("clr_mid_busy", busy, 0);
    win_q.delete();
    no_pulse_for(25, "clr_mid");
    check("clr_mid_hold", data_out, dprev);

    // clr and e_in on the same edge: sample discarded, ovr untouched.
    @(negedge clk);
    clr = 1'b1; e_in = 1'b1; data_in = 10'd1000;
    @(posedge clk); #1;
    clr = 1'b0; e_in = 1'b0;
    check("clr_win_ovr", ovr, 0);
    check("clr_win_busy", busy, 0);
    do_sample(40, 4, "after_clr_win", got);

    // Randomised samples and occasional window changes against the model.
    m = 4;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 19) == 0) m = int'($urandom_range(0, 300));
      do_sample(int'($urandom_range(0, 1023)), m, $sformatf("rnd%0d", i), got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
